// File: rtl/mod_tx_scheduler_pkg.sv
// rtl/mod_tx_scheduler_pkg.sv - shared types and decode helpers for the transmit scheduler
package mod_pkg;

  typedef enum logic [1:0] {QA, QB, QC, QD} quad_t;
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic MODE_ASK = 1'b0;
  localparam logic MODE_FSK = 1'b1;

  // Returns {p,s} for the mixer select lines.
  function automatic logic [1:0] quad_ps(input quad_t q);
    logic [1:0] ps;
    case (q)
      QA:      ps = 2'b00;
      QB:      ps = 2'b10;
      QC:      ps = 2'b01;
      default: ps = 2'b11;
    endcase
    return ps;
  endfunction

  function automatic quad_t quad_next(input quad_t q);
    quad_t n;
    case (q)
      QA:      n = QB;
      QB:      n = QC;
      QC:      n = QD;
      default: n = QA;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mod_tx_scheduler_if.sv
// rtl/mod_tx_scheduler_if.sv - byte handshake and modulator select bundle
interface mod_tx_scheduler_if;
  logic       mode;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic       p;
  logic       s;
  logic       amp;
  logic       sym_strobe;
  logic       frame_done;

  modport master (
    output mode, din, din_valid,
    input  din_ready, busy, p, s, amp, sym_strobe, frame_done
  );

  modport slave (
    input  mode, din, din_valid,
    output din_ready, busy, p, s, amp, sym_strobe, frame_done
  );
endinterface

// File: rtl/mod_tx_scheduler_phase_accum.sv
// rtl/mod_tx_scheduler_phase_accum.sv - phase accumulator driving the four-quadrant carrier FSM
module phase_accum
  import mod_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] step,
  output quad_t            quadrant,
  output logic             carry
);

  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   sum;

  // One extra bit so the overflow is visible as the carry.
  assign sum   = {1'b0, acc} + {1'b0, step};
  assign carry = sum[CNT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      quadrant <= QA;
    end else if (clr) begin
      acc      <= '0;
      quadrant <= QA;
    end else if (en) begin
      acc <= sum[CNT_W-1:0];
      if (carry) quadrant <= quad_next(quadrant);
    end
  end

endmodule

// File: rtl/mod_tx_scheduler.sv
// rtl/mod_tx_scheduler.sv - serialises bytes MSB first into symbols and sequences the carrier phase
module mod_tx_scheduler
  import mod_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int STEP_LO = 1,
  parameter int STEP_HI = 2,
  parameter int SYM_LEN = 256
) (
  input logic clk,
  input logic rst,
  mod_tx_scheduler_if.slave bus
);

  localparam int SC_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;

  state_t           state;
  logic [7:0]       byte_r;
  logic             mode_r;
  logic [2:0]       bit_idx;
  logic [SC_W-1:0]  sym_cnt;
  logic             frame_done_r;

  logic             in_send;
  logic             cur_bit;
  logic             last_sym;
  logic             frame_end;
  logic             clr;
  logic [CNT_W-1:0] step;
  quad_t            quad;
  logic             carry_unused;

  assign in_send   = (state == SEND);
  assign cur_bit   = byte_r[bit_idx];
  assign last_sym  = (sym_cnt == SC_W'(SYM_LEN - 1));
  assign frame_end = in_send && last_sym && (bit_idx == 3'd0);
  assign step      = (mode_r == MODE_FSK && cur_bit) ? CNT_W'(STEP_HI) : CNT_W'(STEP_LO);
  // Phase is only reset when the frame really ends, so back-to-back bytes stay continuous.
  assign clr       = !in_send || (frame_end && !bus.din_valid);

  phase_accum #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (in_send),
    .step     (step),
    .quadrant (quad),
    .carry    (carry_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_r       <= '0;
      mode_r       <= MODE_ASK;
      bit_idx      <= '0;
      sym_cnt      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            byte_r  <= bus.din;
            mode_r  <= bus.mode;
            bit_idx <= 3'd7;
            sym_cnt <= '0;
            state   <= SEND;
          end
        end
        default: begin
          if (last_sym) begin
            sym_cnt <= '0;
            if (bit_idx == 3'd0) begin
              // Chained byte keeps the frame's mode.
              if (bus.din_valid) begin
                byte_r  <= bus.din;
                bit_idx <= 3'd7;
              end else begin
                state        <= IDLE;
                frame_done_r <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx - 3'd1;
            end
          end else begin
            sym_cnt <= sym_cnt + SC_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.din_ready     = !in_send || frame_end;
  assign bus.busy          = in_send;
  assign {bus.p, bus.s}    = quad_ps(quad);
  assign bus.amp           = in_send && (mode_r == MODE_FSK || cur_bit);
  assign bus.sym_strobe    = in_send && (sym_cnt == '0);
  assign bus.frame_done    = frame_done_r;

endmodule

// File: tb/tb_mod_tx_scheduler.sv
// tb/tb_mod_tx_scheduler.sv - scoreboard bench for the transmit scheduler
module tb_mod_tx_scheduler;

  localparam int CNT_W   = 6;
  localparam int STEP_LO = 1;
  localparam int STEP_HI = 2;
  localparam int SYM_LEN = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  mod_tx_scheduler_if bus();

  mod_tx_scheduler #(
    .CNT_W(CNT_W), .STEP_LO(STEP_LO), .STEP_HI(STEP_HI), .SYM_LEN(SYM_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Record layout: {din_ready, busy, p, s, amp, sym_strobe, frame_done}
  logic [6:0] exp_q[$];
  logic       mon_en = 1'b0;
  int         strobe_cnt = 0;
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  logic [6:0] mon_act;
  logic [6:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.din_ready, bus.busy, bus.p, bus.s, bus.amp, bus.sym_strobe, bus.frame_done};
  endfunction

  function automatic logic [1:0] ps_of(input int q);
    case (q)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input int n, input logic m);
    int acc;
    int q;
    int st;
    logic [7:0] by;
    logic bv;
    acc = 0;
    q = 0;
    for (int i = 0; i < n; i++) begin
      by = (i == 0) ? b0 : b1;
      for (int k = 7; k >= 0; k--) begin
        bv = by[k];
        st = (m && bv) ? STEP_HI : STEP_LO;
        for (int c = 0; c < SYM_LEN; c++) begin
          exp_q.push_back({(k == 0 && c == SYM_LEN - 1), 1'b1, ps_of(q), (m ? 1'b1 : bv), (c == 0), 1'b0});
          acc += st;
          if (acc >= (1 << CNT_W)) begin
            acc -= (1 << CNT_W);
            q = (q + 1) % 4;
          end
        end
      end
    end
    exp_q.push_back(7'b1000001);
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en && (bus.busy || bus.frame_done)) begin
      mon_act = outs();
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output at cycle %0d: got 0x%0h expected no activity", cyc, mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_record", 32'(mon_act), 32'(mon_exp));
      end
      if (bus.sym_strobe) strobe_cnt++;
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic wait_ready(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.din_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input int n,
                      input logic m, input logic toggle);
    logic ok;
    int a_cyc;
    push_frame(b0, b1, n, m);
    strobe_cnt = 0;
    fd_cnt = 0;
    fd_cyc = 0;
    wait_ready(10, ok);
    check("ready_before_frame", 32'(ok), 32'd1);
    a_cyc = cyc;
    bus.din = b0;
    bus.mode = m;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    if (n == 1) begin
      bus.din_valid = 1'b0;
    end else begin
      bus.din = b1;
      wait_ready(3000, ok);
      check("second_ready_cycle", 32'(cyc - a_cyc), 32'd2048);
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      if (toggle) bus.mode = ~m;
    end
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("frame_done_latency", 32'(fd_cyc - a_cyc), 32'(8 * SYM_LEN * n + 1));
    check("strobe_count", 32'(strobe_cnt), 32'(8 * n));
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    @(negedge clk);
    #1;
    check("idle_after_frame", 32'(outs()), 32'b1000000);
  endtask

  initial begin
    logic ok;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(outs()), 32'b1000000);
    rst = 1'b0;

    // Byte cut by reset in the middle of bit 3; not scoreboarded.
    wait_ready(10, ok);
    bus.din = 8'h5A;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    repeat (4 * SYM_LEN + 100) @(posedge clk);
    #3;
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'b1000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    send(8'hA5, 8'h00, 1, 1'b0, 1'b0);
    send(8'h0F, 8'h00, 1, 1'b1, 1'b0);
    send(8'h3C, 8'hC3, 2, 1'b0, 1'b0);
    send(8'h96, 8'h69, 2, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_tx_scheduler.md
# mod_tx_scheduler

Byte-to-symbol transmit scheduler for the ASK/FSK transmitter. Accepts bytes over a valid/ready handshake, serialises them MSB first into fixed-length symbols, and sequences an embedded phase generator (phase accumulator plus four-quadrant FSM) to produce the quadrature select outputs `p`/`s` and the amplitude enable. It sits between the byte source and the analog/mixer select logic. It sets carrier step (FSK) or amplitude (ASK) per bit.

## Interface
- `CNT_W`, 6 — phase accumulator width; quadrant advances on accumulator overflow
- `STEP_LO`, 1 — accumulator increment for ASK, and for FSK bit 0
- `STEP_HI`, 2 — accumulator increment for FSK bit 1
- `SYM_LEN`, 256 — clocks per symbol (bit); must be ≥ 2
- `clk` in 1 — clock
- `rst` in 1 — reset, asynchronous, active-high
- `mode` in 1 — 0 = ASK, 1 = FSK; sampled only on byte acceptance from IDLE
- `din` in 8 — byte to transmit
- `din_valid` in 1 — byte available
- `din_ready` out 1 — scheduler can accept a byte this cycle
- `busy` out 1 — high while in SEND
- `p`, `s` out 1 each — quadrant select: A=00, B=10, C=01, D=11 (`p`,`s`)
- `amp` out 1 — carrier amplitude enable
- `sym_strobe` out 1 — one-cycle pulse on the first cycle of every symbol
- `frame_done` out 1 — one-cycle pulse on the cycle the block returns to IDLE

## Operation
- Control FSM has two states: IDLE and SEND.
- **IDLE**
  - `din_ready`=1; `busy`, `p`, `s`, `amp`, `sym_strobe` = 0.
  - Accumulator holds 0 and quadrant holds A.
  - On `din_valid` the byte and `mode` are latched and the FSM goes to SEND.
- **SEND**
  - `bit_idx` counts 7→0 and `sym_cnt` counts 0→SYM_LEN-1 within each bit.
  - Current bit b = byte[bit_idx].
  - ASK: step = STEP_LO; `amp` = b.
  - FSK: step = b ? STEP_HI : STEP_LO; `amp` = 1.
- **Phase accumulator**
  - acc ← (acc + step) mod 2^CNT_W.
  - carry = (acc + step) ≥ 2^CNT_W, computed CNT_W+1 bits wide.
  - On carry the quadrant advances A→B→C→D→A.
  - Phase is continuous across bit and byte boundaries within a frame.
- **Last cycle of bit 0** (sym_cnt = SYM_LEN-1, bit_idx = 0):
  - `din_ready`=1.
  - If `din_valid`: the new byte is latched (`mode` is NOT re-sampled), and the next cycle starts its bit 7 with no gap.
  - Otherwise the FSM goes to IDLE next cycle, `frame_done` pulses on that cycle, and acc/quadrant clear.
- `din_ready`=0 on all other SEND cycles.
- A frame is a sequence of back-to-back bytes. `mode` is fixed for the whole frame.
- Reset:
  - `rst` clears everything immediately: FSM=IDLE, acc=0, quadrant=A, counters=0, all outputs at IDLE values, `frame_done`=0.
  - A byte in flight is dropped.

## Timing
- Accept at cycle t. From t+1: `busy`=1, `sym_strobe`=1, bit 7 drives `amp`/step, and acc starts stepping.
- Bit k occupies cycles t+1+(7-k)·SYM_LEN … t+(8-k)·SYM_LEN.
- A single byte gives `frame_done` at t+8·SYM_LEN+1 (default 2049).
- With STEP_LO=1 the quadrant advances every 2^CNT_W clocks (64).
- With STEP_HI=2 it advances every 2^(CNT_W-1) clocks (32).
- Outputs are registered or decoded from registered state; there are no combinational paths from `din`/`mode` to outputs.
- `din_ready` depends only on registered state; it has no path from `din_valid`.

## Structure
- Package `mod_pkg`:
  - quadrant enum {QA, QB, QC, QD}
  - control state enum {IDLE, SEND}
  - constants MODE_ASK=0 and MODE_FSK=1
  - quadrant→{p,s} decode function
- Sub-module `phase_accum`:
  - inputs: clk, rst, clr, en, step[CNT_W-1:0]
  - outputs: quadrant, carry
  - contains the accumulator and the quadrant FSM
- The top level holds the control FSM, the shift/bit counter, the symbol counter and the handshake.

## Test plan
- Reset mid-bit 3 of a byte → next cycle `p`=`s`=`amp`=`busy`=0, `din_ready`=1; a new byte is accepted cleanly afterwards.
- ASK, `din`=0xA5, defaults:
  - `amp` per 256-cycle bit = 1,0,1,0,0,1,0,1.
  - (`p`,`s`) = 00/10/01/11 every 64 cycles within each bit.
  - 8 `sym_strobe` pulses; `frame_done` at t+2049.
- FSK, `din`=0x0F:
  - Bits 7..4 advance the quadrant every 64 cycles; bits 3..0 every 32 cycles.
  - `amp`=1 throughout; phase is continuous at the 4→3 boundary (no quadrant reset).
- Back-to-back 0x3C then 0xC3 with `din_valid` held:
  - `din_ready` is high only at t and t+2048.
  - 16 contiguous symbols and a single `frame_done` at t+4097.
- `mode` toggled 0→1 during the second byte of an ASK frame → `amp` still follows the bits, and the step stays STEP_LO.
- `din_valid` low at the last cycle of bit 0 → IDLE and `frame_done` next cycle; acc=0 and quadrant=A the following cycle.
